// File: rtl/riscv_core_pkg.sv
// Shared core types: XLEN, NOP encoding, fetch buffer entry and counter-width helpers.
package riscv_core_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Bits needed to hold a count in 0..n inclusive.
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // Bits needed to index n entries (at least 1).
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// In-order {pc,instr} buffer between fetch and decode; flush wins over push/pop, head reads 0 when empty.
module if_fetch_fifo
   import riscv_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush_i,
   input  logic                        push_i,
   input  fetch_entry_t                push_data_i,
   input  logic                        pop_i,
   output fetch_entry_t                head_o,
   output logic [cnt_w(DEPTH)-1:0]     count_o
);

   localparam int unsigned IW = idx_w(DEPTH);
   localparam int unsigned CW = cnt_w(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [IW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok, pop_ok;

   assign push_ok = push_i && !flush_i;
   assign pop_ok  = pop_i && !flush_i && (count_q != '0);

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + IW'(1);
         if (pop_ok)  rd_d = rd_q + IW'(1);
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the head is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_q] <= push_data_i;
   end

   assign head_o  = (count_q == '0) ? '0 : mem_q[rd_q];
   assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the fetch PC, issues in-order imem reads under a credit rule and buffers results for decode.
// Optional IF_FETCH_PERF_EN adds perf_fetched / perf_dropped counters.
module if_fetch_queue
   import riscv_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned     DEPTH    = 4,
   parameter int unsigned     MAX_OUT  = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr
`ifdef IF_FETCH_PERF_EN
  ,output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_dropped
`endif
);

   localparam int unsigned CW = cnt_w(DEPTH);
   localparam int unsigned OW = cnt_w(MAX_OUT);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redirect_pc_al;
   logic [OW-1:0]   live_q, live_d, stale_q, stale_d;
   logic [CW-1:0]   fifo_count;
   logic            req_fire, rsp_keep, rsp_drop, pop;
   logic            unused_pc_lsb;
   fetch_entry_t    head, push_entry;

   assign redirect_pc_al = {redirect_pc[XLEN-1:2], 2'b00};
   assign unused_pc_lsb  = ^redirect_pc[1:0];

   // Credit rule: every outstanding kept response has a guaranteed buffer slot.
   assign imem_req_valid = rst_n && !redirect_valid
                        && ((32'(live_q) + 32'(fifo_count)) < DEPTH)
                        && ((32'(live_q) + 32'(stale_q)) < MAX_OUT);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_keep = imem_rsp_valid && (stale_q == '0) && !redirect_valid;
   assign rsp_drop = imem_rsp_valid && !rsp_keep;

   assign push_entry = '{pc: rsp_pc_q, instr: imem_rsp_data};
   assign pop        = id_valid && id_ready;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      live_d     = live_q;
      stale_d    = stale_q;
      if (redirect_valid) begin
         // Everything in flight becomes stale; a response this cycle retires one of them.
         fetch_pc_d = redirect_pc_al;
         rsp_pc_d   = redirect_pc_al;
         live_d     = '0;
         stale_d    = stale_q + live_q - OW'(imem_rsp_valid);
      end else begin
         if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (rsp_keep) rsp_pc_d   = rsp_pc_q + XLEN'(4);
         live_d = live_q + OW'(req_fire) - OW'(rsp_keep);
         if (rsp_drop) stale_d = stale_q - OW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         live_q     <= '0;
         stale_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         live_q     <= live_d;
         stale_q    <= stale_d;
      end
   end

   if_fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (redirect_valid),
      .push_i      (rsp_keep),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .head_o      (head),
      .count_o     (fifo_count)
   );

   assign id_valid = (fifo_count != '0);
   assign id_pc    = head.pc;
   assign id_instr = head.instr;

`ifdef IF_FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_dropped <= '0;
      end else begin
         if (rsp_keep) perf_fetched <= perf_fetched + 32'd1;
         if (rsp_drop) perf_dropped <= perf_dropped + 32'd1;
      end
   end
`endif

   a_rsp_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> ((live_q != '0) || (stale_q != '0)));

endmodule
